mdu_param: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. Holds the HI/LO pair, executes signed/unsigned multiply, divide and multiply-accumulate with configurable latencies, and reports `busy` to the hazard controller. Unlike the fixed-latency unit it replaces, it supports `cancel` so a precise exception or interrupt can discard an in-flight operation without disturbing HI/LO.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 53 +++++
 rtl/mdu_param.sv | 101 ++++++++++
 tb/tb_mdu_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM encoding and op classifiers.
// The MDU_* codes are also what the E-stage controller drives on its MDUOp output.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MADD  = 4'd5;
  localparam logic [3:0] MDU_MADDU = 4'd6;
  localparam logic [3:0] MDU_MSUB  = 4'd7;
  localparam logic [3:0] MDU_MSUBU = 4'd8;
  localparam logic [3:0] MDU_MTHI  = 4'd9;
  localparam logic [3:0] MDU_MTLO  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator: {pend_hi, pend_lo} for multiply, accumulate and divide ops.
// Divide by zero and non-arithmetic codes hand back the current HI/LO untouched.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] pend_hi,
  output logic [WIDTH-1:0] pend_lo
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    prod_s, prod_u, acc;
  logic             sdiv;
  logic [WIDTH-1:0] mag_a, mag_b, divisor, q_u, r_u, q, r;

  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc    = {hi, lo};

    // Signed divide runs on magnitudes; min / -1 falls out as quotient min, remainder 0.
    sdiv    = (op == MDU_DIV);
    mag_a   = (sdiv && a[WIDTH-1]) ? -a : a;
    mag_b   = (sdiv && b[WIDTH-1]) ? -b : b;
    divisor = (b == '0) ? WIDTH'(1) : mag_b;
    q_u     = mag_a / divisor;
    r_u     = mag_a % divisor;
    q       = (sdiv && (a[WIDTH-1] ^ b[WIDTH-1])) ? -q_u : q_u;
    r       = (sdiv && a[WIDTH-1]) ? -r_u : r_u;

    {pend_hi, pend_lo} = acc;
    case (op)
      MDU_MULT:  {pend_hi, pend_lo} = prod_s;
      MDU_MULTU: {pend_hi, pend_lo} = prod_u;
      MDU_MADD:  {pend_hi, pend_lo} = acc + prod_s;
      MDU_MADDU: {pend_hi, pend_lo} = acc + prod_u;
      MDU_MSUB:  {pend_hi, pend_lo} = acc - prod_s;
      MDU_MSUBU: {pend_hi, pend_lo} = acc - prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (b != '0) {pend_hi, pend_lo} = {r, q};
      end
      default: {pend_hi, pend_lo} = acc;
    endcase
  end

endmodule

// File: rtl/mdu_param.sv
// Multi-cycle MDU for the E stage: HI/LO registers, latency down-counter and cancel handling.
//   state   | meaning
//   ST_IDLE | no op in flight; MTHI/MTLO write directly, arithmetic ops launch
//   ST_RUN  | result held in pend_hi/pend_lo, counter running down to commit
module mdu_param
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo, calc_hi, calc_lo;
  logic             launch, commit, wr_hi, wr_lo;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .pend_hi (calc_hi),
    .pend_lo (calc_lo)
  );

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (op == MDU_MTHI) wr_hi = 1'b1;
          else if (op == MDU_MTLO) wr_lo = 1'b1;
          else if (is_mul_op(op) || is_div_op(op)) begin
            launch    = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cancel) state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      if (launch) begin
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
        cnt     <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (state == ST_RUN) begin
        cnt <= (state_nxt == ST_IDLE) ? '0 : cnt - CNT_W'(1);
      end
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_mdu_param.sv
// Bench for mdu_param: directed cases plus randomized ops against a cycle-level arithmetic model.
module tb_mdu_param;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;

  logic        start_s, cancel_s, busy_s;
  logic [3:0]  op_s;
  logic [15:0] a_s, b_s, hi_s, lo_s;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  always #5 clk = ~clk;

  mdu_param dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy)
  );

  mdu_param #(.WIDTH(16), .MULT_CYCLES(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .op(op_s), .a(a_s), .b(b_s),
    .cancel(cancel_s), .hi(hi_s), .lo(lo_s), .busy(busy_s)
  );

  function automatic logic [63:0] ref_calc(input logic [3:0] o, input logic [31:0] x, y, h, l);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'b0, x};
    longint unsigned uy = {32'b0, y};
    logic [63:0]     acc = {h, l};
    logic [63:0]     ps = sx * sy;
    logic [63:0]     pu = ux * uy;
    longint          q, r;
    case (o)
      MDU_MULT:  return ps;
      MDU_MULTU: return pu;
      MDU_MADD:  return acc + ps;
      MDU_MADDU: return acc + pu;
      MDU_MSUB:  return acc - ps;
      MDU_MSUBU: return acc - pu;
      MDU_DIV: begin
        if (y == 32'd0) return acc;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
      MDU_DIVU: begin
        if (y == 32'd0) return acc;
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return acc;
    endcase
  endfunction

  // Reference: one pending result plus the number of busy cycles still owed.
  always @(posedge clk) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (cancel) m_left = 0;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) {m_hi, m_lo} = m_pend;
      end
    end else if (start && !cancel) begin
      case (op)
        MDU_MTHI: m_hi = a;
        MDU_MTLO: m_lo = a;
        MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
          m_pend = ref_calc(op, a, b, m_hi, m_lo); m_left = MULT_N;
        end
        MDU_DIV, MDU_DIVU: begin
          m_pend = ref_calc(op, a, b, m_hi, m_lo); m_left = DIV_N;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (hi !== m_hi || lo !== m_lo || busy !== (m_left > 0)) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=%b",
                 $time, hi, lo, busy, m_hi, m_lo, (m_left > 0));
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, y, output int nb);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      nb++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nb;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MDU_NOP; a = '0; b = '0;
    start_s = 1'b0; cancel_s = 1'b0; op_s = MDU_NOP; a_s = '0; b_s = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_small", {31'd0, busy_s, hi_s, lo_s}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, nb);
    check("mult_busy", 64'(nb), 64'd5);
    check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(MDU_DIVU, 32'd100, 32'd7, nb);
    check("divu_busy", 64'(nb), 64'd10);
    check("divu_res", {hi, lo}, {32'd2, 32'd14});

    run_op(MDU_DIV, -32'sd7, 32'd2, nb);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check("div_min_m1", {hi, lo}, {32'h0, 32'h8000_0000});

    run_op(MDU_MTHI, 32'h11, 32'd0, nb);
    run_op(MDU_MTLO, 32'h22, 32'd0, nb);
    run_op(MDU_DIV, 32'd55, 32'd0, nb);
    check("div0_busy", 64'(nb), 64'd10);
    check("div0_res", {hi, lo}, {32'h11, 32'h22});

    run_op(MDU_MTHI, 32'd0, 32'd0, nb);
    run_op(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, nb);
    run_op(MDU_MADDU, 32'd1, 32'd1, nb);
    check("maddu_res", {hi, lo}, {32'd1, 32'd0});

    run_op(MDU_MTHI, 32'd5, 32'd0, nb);
    run_op(MDU_MTLO, 32'd6, 32'd0, nb);
    start = 1'b1; op = MDU_MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("cancel_pre_busy", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hilo", {hi, lo}, {32'd5, 32'd6});

    start = 1'b1; cancel = 1'b1; op = MDU_MTLO; a = 32'h99;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("mtlo_cancel", {32'd0, lo}, {32'd0, 32'd6});

    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_mid_div", {31'd0, busy, hi[15:0], lo[15:0]}, 64'd0);
    check("reset_mid_div_hilo", {hi, lo}, 64'd0);

    for (int it = 0; it < 300; it++) begin
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2, 3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      start = 1'b1; op = ro; a = ra; b = rb;
      cancel = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (!busy) break;
        cancel = ($urandom_range(0, 14) == 0);
        start  = ($urandom_range(0, 7) == 0);
        op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
      end
      if (busy) begin
        checks++;
        failures++;
        $display("FAIL busy_timeout got busy=%b want 0 after 40 cycles", busy);
      end
    end

    start_s = 1'b1; op_s = MDU_MULTU; a_s = 16'hFFFF; b_s = 16'hFFFF;
    @(posedge clk); #1;
    start_s = 1'b0;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy_s) break;
      nb++;
      @(posedge clk); #1;
    end
    check("small_busy", 64'(nb), 64'd1);
    check("small_res", {32'd0, hi_s, lo_s}, {32'd0, 16'hFFFE, 16'h0001});

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
